// File: rtl/muldiv_controller.sv
// HI/LO multiply/divide sequencer: iterative shift-add multiply, restoring divide, sign fix-up.
// Optional macro MULDIV_FAST_MULT_EN replaces the iterative multiply with a single-cycle 32x32 multiply.
package selector;
    typedef enum logic [2:0] {
        MULDIV_NCARE = 3'd0,
        MULDIV_MULT  = 3'd1,
        MULDIV_MULTU = 3'd2,
        MULDIV_DIV   = 3'd3,
        MULDIV_DIVU  = 3'd4
    } muldiv_funct_t;
endpackage

module muldiv_controller #(
    parameter int ITER = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  selector::muldiv_funct_t funct,
    input  logic [31:0]             rs,
    input  logic [31:0]             rt,
    input  logic                    flush,
    input  logic                    hilo_read,
    output logic                    busy,
    output logic                    stall,
    output logic                    done,
    output logic [31:0]             hi,
    output logic [31:0]             lo
);
    import selector::*;

    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   acc;     // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [31:0]   opb;     // multiplicand or divisor magnitude
    logic          op_div;
    logic          neg_q;
    logic          neg_r;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    logic        is_signed, is_div, go;
    logic        rs_neg, rt_neg;
    logic [31:0] mag_rs, mag_rt;
    logic [63:0] mul_next, div_next;
    logic [63:0] prod_fix;
    logic [31:0] q_fix, r_fix;

    always_comb begin
        is_signed = (funct == MULDIV_MULT) || (funct == MULDIV_DIV);
        is_div    = (funct == MULDIV_DIV)  || (funct == MULDIV_DIVU);
        go        = start && !flush && (funct != MULDIV_NCARE);
        rs_neg    = is_signed && $signed(rs) < 0;
        rt_neg    = is_signed && $signed(rt) < 0;
        mag_rs    = rs_neg ? neg32(rs) : rs;
        mag_rt    = rt_neg ? neg32(rt) : rt;
    end

`ifdef MULDIV_FAST_MULT_EN
    always_comb begin
        mul_next = 64'(opb) * 64'(acc[31:0]);
    end
`else
    logic [32:0] mul_sum;
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
    end
`endif

    // Restoring step: the top bit of the 33-bit difference is the borrow.
    logic [32:0] div_shift, div_diff;
    always_comb begin
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, opb};
        if (!div_diff[32])
            div_next = {div_diff[31:0], acc[30:0], 1'b1};
        else
            div_next = {div_shift[31:0], acc[30:0], 1'b0};
    end

    always_comb begin
        prod_fix = neg_q ? neg64(acc) : acc;
        q_fix    = neg_q ? neg32(acc[31:0])  : acc[31:0];
        r_fix    = neg_r ? neg32(acc[63:32]) : acc[63:32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        cnt    <= '0;
                        op_div <= is_div;
                        neg_q  <= rs_neg ^ rt_neg;
                        neg_r  <= is_div && rs_neg;
                        if (is_div) begin
                            acc   <= {32'd0, mag_rs};
                            opb   <= mag_rt;
                            state <= DIV;
                        end else begin
                            acc   <= {32'd0, mag_rt};
                            opb   <= mag_rs;
                            state <= MUL;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    acc <= mul_next;
`ifdef MULDIV_FAST_MULT_EN
                    state <= FIX;
`else
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= FIX;
`endif
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (op_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == MUL) || (state == DIV) || (state == FIX);
    assign done  = (state == DONE);
    assign stall = busy && (start || hilo_read);

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller: directed corner cases plus randomized operations.
module tb_muldiv_controller;
    import selector::*;

    localparam int ITER = 32;
    localparam int DIV_LAT = ITER + 2;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = ITER + 2;
`endif

    logic          clk = 0;
    logic          reset = 1;
    logic          start = 0;
    muldiv_funct_t funct = MULDIV_NCARE;
    logic [31:0]   rs = 0, rt = 0;
    logic          flush = 0;
    logic          hilo_read = 0;
    logic          busy, stall, done;
    logic [31:0]   hi, lo;

    muldiv_controller #(.ITER(ITER)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .rs(rs), .rt(rt),
        .flush(flush), .hilo_read(hilo_read), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: native 64-bit arithmetic plus the no-trap divide-by-zero rule.
    function automatic void model(input muldiv_funct_t f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb2, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        h = 0;
        l = 0;
        case (f)
            MULDIV_MULT: begin
                p = 64'(sa * sb2);
                h = p[63:32]; l = p[31:0];
            end
            MULDIV_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32]; l = p[31:0];
            end
            MULDIV_DIVU: begin
                if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
                else begin l = a / b; h = a % b; end
            end
            MULDIV_DIV: begin
                if (b == 0) begin
                    l = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    q = sa / sb2;
                    r = sa % sb2;
                    p = 64'(q); l = p[31:0];
                    p = 64'(r); h = p[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    function automatic int lat_of(input muldiv_funct_t f);
        return (f == MULDIV_DIV || f == MULDIV_DIVU) ? DIV_LAT : MUL_LAT;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done at cycle %0d with no operation outstanding", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Presents a start from a negedge and holds it until it is no longer stalled.
    task automatic drive(input muldiv_funct_t f, input logic [31:0] a, input logic [31:0] b, output int n);
        int waits = 0;
        start = 1; funct = f; rs = a; rt = b;
        #1;
        while (stall && waits < 200) begin
            @(negedge clk); #1; waits++;
        end
        if (stall) begin
            checks++; errors++;
            $display("FAIL start_accept: still stalled after %0d cycles, expected release", waits);
        end
        n = cyc;
        @(negedge clk);
        start = 0; funct = MULDIV_NCARE;
    endtask

    task automatic push_model(input muldiv_funct_t f, input logic [31:0] a, input logic [31:0] b, input int n);
        exp_t e;
        model(f, a, b, e.hi, e.lo);
        e.cyc = n + lat_of(f);
        sb.push_back(e);
    endtask

    task automatic push_const(input muldiv_funct_t f, input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.hi = h; e.lo = l; e.cyc = n + lat_of(f);
        sb.push_back(e);
    endtask

    task automatic op_const(input muldiv_funct_t f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] h, input logic [31:0] l);
        int n;
        drive(f, a, b, n);
        push_const(f, h, l, n);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(negedge clk); k++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, n1, n2, cnt, bad;
        muldiv_funct_t f;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        reset = 0;
        @(negedge clk);

        // MULTU max operands, with busy window length
        drive(MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        push_const(MULDIV_MULTU, 32'hFFFF_FFFE, 32'h0000_0001, n);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++; @(negedge clk);
        end
        chk("busy_cycles", cnt, MUL_LAT - 1);
        drain();

        op_const(MULDIV_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        drain();
        op_const(MULDIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drain();
        op_const(MULDIV_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        drain();
        op_const(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        drain();

        // hilo_read stall window during a DIV
        drive(MULDIV_DIV, 32'd1000, 32'd7, n);
        push_model(MULDIV_DIV, 32'd1000, 32'd7, n);
        while (cyc < n + 5) @(negedge clk);
        bad = 0;
        for (int k = 5; k <= 34; k++) begin
            hilo_read = 1;
            #1;
            if (stall !== (k <= 33)) bad++;
            @(negedge clk);
        end
        hilo_read = 0;
        chk("stall_window_errors", bad, 0);
        drain();

        // back-to-back DIV: second start held until the DONE cycle
        drive(MULDIV_DIV, 32'hFFFF_FF00, 32'd3, n1);
        push_model(MULDIV_DIV, 32'hFFFF_FF00, 32'd3, n1);
        drive(MULDIV_DIVU, 32'hDEAD_BEEF, 32'd16, n2);
        push_model(MULDIV_DIVU, 32'hDEAD_BEEF, 32'd16, n2);
        chk("b2b_accept_cycle", n2, n1 + DIV_LAT);
        drain();

        // flush mid-DIV leaves the previous result in place
        op_const(MULDIV_DIVU, 32'h451, 32'h20, 32'h11, 32'h22);
        drain();
        drive(MULDIV_DIV, 32'h1234_5678, 32'd9, n);
        while (cyc < n + 10) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        repeat (40) @(negedge clk);
        chk("flush_hi", hi, 32'h11);
        chk("flush_lo", lo, 32'h22);

        // reset mid-operation clears everything; next op runs normally
`ifdef MULDIV_FAST_MULT_EN
        f = MULDIV_DIV;
`else
        f = MULDIV_MULT;
`endif
        drive(f, 32'h0000_7777, 32'hFFFF_0001, n);
        while (cyc < n + 20) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        drive(MULDIV_MULT, 32'h0001_0003, 32'hFFFF_FFF0, n);
        push_model(MULDIV_MULT, 32'h0001_0003, 32'hFFFF_FFF0, n);
        drain();

        // randomized mix, some back-to-back, some NCARE starts
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 8))
                0, 1:    f = MULDIV_MULT;
                2, 3:    f = MULDIV_MULTU;
                4, 5:    f = MULDIV_DIV;
                6, 7:    f = MULDIV_DIVU;
                default: f = MULDIV_NCARE;
            endcase
            a = pick_operand();
            b = pick_operand();
            drive(f, a, b, n);
            if (f != MULDIV_NCARE) push_model(f, a, b, n);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end
endmodule
